// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Transmit-side byte buffer placed directly in front of a uart. A producer
//   can push one byte per clock. Up to DEPTH bytes are held here. Bytes are
//   handed to the uart one at a time, in push order, through its
//   wr_en / wr_rdy handshake.
//
//   A byte is moved out of the FIFO into the uart_din holding register when
//   it is loaded. From that point it no longer counts toward `count`, so the
//   block can hold DEPTH queued bytes plus one presented byte.
//
// Ports
//   clk          in   1        system clock, rising edge
//   rst_n        in   1        asynchronous active-low reset
//   push         in   1        producer write strobe
//   push_data    in   WIDTH    byte to enqueue when push=1
//   full         out  1        count == DEPTH (registered)
//   empty        out  1        count == 0     (registered)
//   count        out  AW+1     queued bytes, excluding the presented byte
//   overflow     out  1        sticky: a push was dropped while full
//   clr_ovf      in   1        clears overflow (a same-cycle drop wins)
//   uart_din     out  WIDTH    byte presented to the uart
//   uart_wr_en   out  1        presented byte valid
//   uart_wr_rdy  in   1        uart ready; transfer on wr_en & wr_rdy
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             overflow,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] uart_din,
  output logic             uart_wr_en,
  input  logic             uart_wr_rdy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  // storage (no reset; contents are don't-care until written)
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_full;
  logic             r_empty;
  logic             r_ovf;
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_din;
  logic             r_wr_en;

  logic             w_push_ok;
  logic             w_drop;
  logic             w_deq;
  logic             w_xfer;
  logic [AW:0]      w_count_nxt;

  // full is the registered flag from before the edge, so a dequeue in the
  // same cycle never makes room for a push.
  assign w_push_ok = push & ~r_full;
  assign w_drop    = push &  r_full;

  // load the next byte only from IDLE; r_empty mirrors count==0
  assign w_deq  = (r_state == ST_IDLE) & ~r_empty;
  assign w_xfer = r_wr_en & uart_wr_rdy;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push_ok, w_deq})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // ---------------------------------------------------------------------------
  // storage write
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
  end

  // ---------------------------------------------------------------------------
  // pointers, occupancy and derived flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_deq)     r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count <= w_count_nxt;
      // flags come from the next count so they line up with count itself
      r_full  <= (w_count_nxt == CNT_FULL);
      r_empty <= (w_count_nxt == '0);
    end
  end

  // ---------------------------------------------------------------------------
  // sticky overflow; a drop in the same cycle as clr_ovf keeps it set
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (clr_ovf) r_ovf <= 1'b0;
  end

  // ---------------------------------------------------------------------------
  // uart handoff FSM
  //   IDLE: load the head byte when one is queued
  //   SEND: hold din/wr_en until the uart takes it
  //   GAP : one low cycle so back-to-back bytes are distinct wr_en pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_din   <= '0;
      r_wr_en <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_deq) begin
            r_din   <= r_mem[r_rd_ptr];
            r_wr_en <= 1'b1;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_xfer) begin
            r_wr_en <= 1'b0;
            r_state <= ST_GAP;
          end
        end
        ST_GAP: begin
          r_wr_en <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_wr_en <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign full       = r_full;
  assign empty      = r_empty;
  assign count      = r_count;
  assign overflow   = r_ovf;
  assign uart_din   = r_din;
  assign uart_wr_en = r_wr_en;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Randomized bench for uart_tx_fifo. A queue-based reference model follows
//   the buffer's rules at the byte level. Accepted bytes are pushed into a
//   scoreboard queue. A monitor checks every byte the DUT hands to the uart
//   against the scoreboard. It also checks the status outputs every cycle.
//   Inputs change 2 time units after the rising edge. Outputs are sampled
//   on the falling edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             push = 1'b0;
  logic [WIDTH-1:0] push_data = '0;
  logic             clr_ovf = 1'b0;
  logic             uart_wr_rdy = 1'b0;
  logic             full, empty, overflow, uart_wr_en;
  logic [AW:0]      count;
  logic [WIDTH-1:0] uart_din;

  always #5 clk = ~clk;

  uart_tx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .push_data(push_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .clr_ovf(clr_ovf), .uart_din(uart_din), .uart_wr_en(uart_wr_en),
    .uart_wr_rdy(uart_wr_rdy)
  );

  // reference model state
  logic [WIDTH-1:0] m_q[$];    // bytes waiting in the buffer
  bit               m_pres;    // a byte is on offer to the uart
  bit               m_gap;     // the idle cycle after a transfer
  bit               m_ovf;
  logic [WIDTH-1:0] sb_q[$];   // every accepted byte, in order

  // monitor state
  int  n_cmp = 0;
  int  n_err = 0;
  int  sb_idx = 0;
  bit  fin_req = 0;
  bit  fin_ack = 0;

  // ---------------------------------------------------------------------------
  // reference model: at each edge decide from the pre-edge situation
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_q.delete();
        m_pres = 0;
        m_gap  = 0;
        m_ovf  = 0;
      end else begin
        bit acc, load, xfer;
        acc  = push && (m_q.size() < DEPTH);
        load = !m_pres && !m_gap && (m_q.size() > 0);
        xfer = m_pres && uart_wr_rdy;
        if (m_gap) m_gap = 0;
        if (xfer) begin m_pres = 0; m_gap = 1; end
        if (load) begin m_pres = 1; void'(m_q.pop_front()); end
        if (acc) begin m_q.push_back(push_data); sb_q.push_back(push_data); end
        if (push && !acc) m_ovf = 1;
        else if (clr_ovf) m_ovf = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // monitor / scoreboard checker
  // ---------------------------------------------------------------------------
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    bit prev_rst = 1;
    forever begin
      @(negedge clk or negedge rst_n);
      if (prev_rst && !rst_n) begin
        // async reset: wr_en must fall without waiting for a clock
        prev_rst = 0;
        #1;
        chk("rst_async_wr_en", uart_wr_en, 0);
        chk("rst_async_count", count, 0);
        sb_idx = sb_q.size();   // queued bytes are discarded
        continue;
      end
      prev_rst = rst_n;
      chk("count",    count,      m_q.size());
      chk("empty",    empty,      m_q.size() == 0);
      chk("full",     full,       m_q.size() == DEPTH);
      chk("overflow", overflow,   m_ovf);
      chk("wr_en",    uart_wr_en, m_pres);
      if (uart_wr_en && uart_wr_rdy) begin
        if (sb_idx < sb_q.size()) begin
          chk("byte_order", uart_din, sb_q[sb_idx]);
          sb_idx++;
        end else begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_byte: got %0h expected none at %0t", uart_din, $time);
        end
      end
      if (fin_req && !fin_ack) begin
        chk("all_delivered", sb_idx, sb_q.size());
        fin_ack = 1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // stimulus
  // ---------------------------------------------------------------------------
  task automatic drive(input bit p, input logic [WIDTH-1:0] d, input bit rdy, input bit clr);
    @(posedge clk);
    #2;
    push = p; push_data = d; uart_wr_rdy = rdy; clr_ovf = clr;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(0, '0, rdy, 0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((m_q.size() != 0 || m_pres || m_gap) && k < 300) begin
      drive(0, '0, 1, 0);
      k++;
    end
    idle(3, 1);
  endtask

  initial begin
    // 1: reset, nothing pushed, uart sees nothing
    #1 rst_n = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    idle(6, 1);

    // 2: single byte; wr_en rises after the second edge
    drive(1, 8'hE8, 1, 0);
    idle(8, 1);

    // 3: back-to-back burst 01..05
    for (int i = 1; i <= 5; i++) drive(1, WIDTH'(i), 1, 0);
    idle(24, 1);

    // 4: uart stalled, 17 accepted, 18th dropped, then clear overflow
    for (int i = 0; i < 17; i++) drive(1, WIDTH'($urandom), 0, 0);
    drive(1, 8'h99, 0, 0);
    idle(3, 0);
    drive(0, '0, 0, 1);
    idle(2, 0);
    // drop and clear in the same cycle: drop wins
    drive(1, 8'h77, 0, 1);
    idle(2, 0);
    drive(0, '0, 0, 1);
    drain();

    // 5: fill, drain past the pointer wrap, then AA/55 behind prior data
    for (int i = 0; i < 16; i++) drive(1, WIDTH'(8'h30 + i), 0, 0);
    idle(2, 1);
    drive(1, 8'hAA, 1, 0);
    drive(1, 8'h55, 1, 0);
    drain();

    // 6: reset in the middle of a send with 3 bytes queued
    for (int i = 0; i < 4; i++) drive(1, WIDTH'(8'hC0 + i), 0, 0);
    idle(2, 0);
    @(posedge clk);
    #2 rst_n = 0; push = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    idle(20, 1);

    // 7: random traffic, alternating stalled and free-running uart phases
    for (int ph = 0; ph < 8; ph++) begin
      for (int i = 0; i < 200; i++) begin
        bit rdy;
        rdy = (ph % 2 == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
        drive($urandom_range(0, 1) == 1, WIDTH'($urandom), rdy, $urandom_range(0, 19) == 0);
      end
    end
    drain();

    // final scoreboard check
    fin_req = 1;
    for (int k = 0; k < 10 && !fin_ack; k++) @(posedge clk);
    if (!fin_ack) begin
      $display("FAIL final_check: monitor did not respond");
      $fatal(1, "final check timeout");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
